// File: rtl/vctr_store_pkg.sv
// Shared defaults and state type for the single-vector byte store.
// Imported by the store top and its flop-array memory.
package vctr_store_pkg;

  localparam int unsigned VS_DATA_W = 8;
  localparam int unsigned VS_DEPTH  = 16;
  localparam int unsigned VS_ADDR_W = 4;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

endpackage : vctr_store_pkg

// File: rtl/vctr_store_mem.sv
// DEPTH x DATA_W flop array: synchronous write, asynchronous read, async clear.
// Holds no control; the top decides when and where to write.
module vctr_store_mem
  import vctr_store_pkg::*;
#(
  parameter int unsigned DATA_W = VS_DATA_W,
  parameter int unsigned DEPTH  = VS_DEPTH,
  parameter int unsigned ADDR_W = VS_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : vctr_store_mem

// File: rtl/vctr_store.sv
// Collects one byte vector, then replays it with its length and XOR checksum.
// Input is held off during replay, so only one vector is ever in flight.
//
//   state    | meaning
//   ST_FILL  | accepting bytes; bytes beyond DEPTH are dropped and flag overflow
//   ST_DRAIN | replaying stored bytes to the consumer; input back-pressured
module vctr_store
  import vctr_store_pkg::*;
#(
  parameter int unsigned DATA_W = VS_DATA_W,
  parameter int unsigned DEPTH  = VS_DEPTH,
  parameter int unsigned ADDR_W = VS_ADDR_W
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W:0]   vec_len,
  output logic [DATA_W-1:0] vec_chk,
  output logic              overflow
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [DATA_W-1:0] chk_q;
  logic [CNT_W-1:0]  vec_len_q;
  logic [DATA_W-1:0] vec_chk_q;
  logic              overflow_q;

  logic              accept;
  logic              wr_full;
  logic              wr_en;
  logic              xfer;
  logic [CNT_W-1:0]  len_d;
  logic [DATA_W-1:0] chk_d;
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    accept  = in_valid && in_ready_q;
    wr_full = (wr_cnt_q == CNT_FULL);
    wr_en   = accept && !wr_full;
    xfer    = out_valid_q && out_ready;
    len_d   = wr_cnt_q;
    chk_d   = chk_q;
    // A saturated vector keeps its count and checksum; the dropped byte counts for neither.
    if (wr_en) begin
      len_d = wr_cnt_q + CNT_ONE;
      chk_d = (wr_cnt_q == '0) ? in_data : (chk_q ^ in_data);
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      wr_cnt_q    <= '0;
      rd_ptr_q    <= '0;
      chk_q       <= '0;
      vec_len_q   <= '0;
      vec_chk_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (wr_en) begin
              wr_cnt_q <= len_d;
              chk_q    <= chk_d;
              if (wr_cnt_q == '0) begin
                overflow_q <= 1'b0;
              end
            end else begin
              overflow_q <= 1'b1;
            end
            if (in_last) begin
              state_q     <= ST_DRAIN;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_last_q  <= (len_d == CNT_ONE);
              rd_ptr_q    <= '0;
              vec_len_q   <= len_d;
              vec_chk_q   <= chk_d;
            end
          end
        end
        ST_DRAIN: begin
          if (xfer) begin
            if (out_last_q) begin
              state_q     <= ST_FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              rd_ptr_q    <= '0;
              wr_cnt_q    <= '0;
              chk_q       <= '0;
            end else begin
              rd_ptr_q   <= rd_ptr_q + 1'b1;
              // Next byte is last when rd_ptr+1 == vec_len-1.
              out_last_q <= (({1'b0, rd_ptr_q} + CNT_TWO) == vec_len_q);
            end
          end
        end
        default: begin
          state_q <= ST_FILL;
        end
      endcase
    end
  end

  vctr_store_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk_i   (clock),
    .rst_i   (rst),
    .we_i    (wr_en),
    .waddr_i (wr_cnt_q[ADDR_W-1:0]),
    .wdata_i (in_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_valid_q ? rd_data : '0;
  assign vec_len   = vec_len_q;
  assign vec_chk   = vec_chk_q;
  assign overflow  = overflow_q;

endmodule : vctr_store

// File: tb/tb_vctr_store.sv
// Bench for vctr_store: directed and random vectors against a queue-based model
// of what one vector should replay as (bytes, length, checksum, overflow).
module tb_vctr_store;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;
  logic [4:0] vec_len;
  logic [7:0] vec_chk;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  vctr_store dut (
    .clock     (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .vec_len   (vec_len),
    .vec_chk   (vec_chk),
    .overflow  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic fill_vec(input logic [7:0] v[$]);
    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL fill_in_ready byte %0d: got %b want 1", i, in_ready);
      end
      if (i == 1) begin
        n_cmp++;
        if (overflow !== 1'b0) begin
          n_err++;
          $display("FAIL ovf_clear_on_first: got %b want 0", overflow);
        end
      end
      in_valid = 1'b1;
      in_data  = v[i];
      in_last  = (i == v.size() - 1);
    end
  endtask

  // mode 0: out_ready always 1, mode 1: 1010..., mode 2: random
  task automatic drain_vec(input logic [7:0] v[$], input int mode, input bit hold_valid);
    int         len;
    logic [7:0] chk;
    bit         ovf;
    int         idx;
    int         cyc;
    bit         r;
    len = (v.size() > DEPTH) ? DEPTH : v.size();
    ovf = (v.size() > DEPTH);
    chk = 8'h00;
    for (int i = 0; i < len; i++) chk ^= v[i];
    idx = 0;
    cyc = 0;
    while (idx < len && cyc < 200) begin
      @(negedge clk);
      if (hold_valid) begin
        in_valid = 1'b1;
        in_last  = 1'(cyc % 2);
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_last  = 1'($urandom_range(0, 1));
        in_data  = 8'($urandom);
      end
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL drain_hs idx %0d: got out_valid=%b in_ready=%b want 1/0", idx, out_valid, in_ready);
      end
      n_cmp++;
      if (out_data !== v[idx]) begin
        n_err++;
        $display("FAIL drain_data idx %0d: got %h want %h", idx, out_data, v[idx]);
      end
      n_cmp++;
      if (out_last !== (idx == len - 1)) begin
        n_err++;
        $display("FAIL drain_last idx %0d: got %b want %b", idx, out_last, (idx == len - 1));
      end
      n_cmp++;
      if (vec_len !== 5'(len) || vec_chk !== chk) begin
        n_err++;
        $display("FAIL drain_len_chk: got len=%0d chk=%h want len=%0d chk=%h", vec_len, vec_chk, len, chk);
      end
      n_cmp++;
      if (overflow !== ovf) begin
        n_err++;
        $display("FAIL drain_overflow: got %b want %b", overflow, ovf);
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      cyc++;
      @(posedge clk);
      if (r) idx++;
    end
    n_cmp++;
    if (idx != len) begin
      n_err++;
      $display("FAIL drain_timeout: got %0d bytes want %0d", idx, len);
    end
    if (mode == 0) begin
      n_cmp++;
      if (cyc != len) begin
        n_err++;
        $display("FAIL drain_rate: got %0d cycles want %0d", cyc, len);
      end
    end
  endtask

  task automatic post_check(input logic [7:0] v[$]);
    @(negedge clk);
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL post_drain: got in_ready=%b out_valid=%b out_last=%b want 1/0/0",
               in_ready, out_valid, out_last);
    end
    n_cmp++;
    if (overflow !== (v.size() > DEPTH)) begin
      n_err++;
      $display("FAIL post_overflow: got %b want %b", overflow, (v.size() > DEPTH));
    end
  endtask

  task automatic run_vec(input logic [7:0] v[$], input int mode, input bit b2b_next);
    fill_vec(v);
    drain_vec(v, mode, b2b_next);
    if (!b2b_next) post_check(v);
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 ||
        vec_len !== 5'd0 || vec_chk !== 8'h00 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got rdy=%b ov=%b ol=%b od=%h len=%0d chk=%h ovf=%b want 1/0/0/00/0/00/0",
               tag, in_ready, out_valid, out_last, out_data, vec_len, vec_chk, overflow);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] v[$];
    v = {8'h11, 8'h22, 8'h33};
    run_vec(v, 0, 1'b0);
    v = {8'hA5};
    run_vec(v, 0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [7:0] v[$];
    v = {};
    for (int i = 0; i < 18; i++) v.push_back(8'(i));
    run_vec(v, 0, 1'b0);
    v = {8'h3C, 8'h7E, 8'h01};
    run_vec(v, 0, 1'b0);
    v = {};
    for (int i = 0; i < 16; i++) v.push_back(8'($urandom));
    run_vec(v, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    logic [7:0] v[$];
    v = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_vec(v, 1, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [7:0] v[$];
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'hF0; in_last = 1'b0;
    @(negedge clk);
    in_data = 8'h0F;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_fill");
    @(negedge clk);
    rst = 1'b0;
    v = {8'h5A, 8'hC3};
    run_vec(v, 0, 1'b0);
    v = {8'h12, 8'h34, 8'h56};
    fill_vec(v);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_drain: got out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    check_reset_vals("reset_mid_drain");
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] a[$];
    logic [7:0] b[$];
    a = {8'h81, 8'h42, 8'h24};
    b = {8'h99, 8'h18, 8'hE7, 8'h66, 8'h3D};
    run_vec(a, 0, 1'b1);
    run_vec(b, 2, 1'b0);
  endtask

  task automatic test_random();
    logic [7:0] v[$];
    int n;
    for (int t = 0; t < 20; t++) begin
      v = {};
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) v.push_back(8'($urandom));
      run_vec(v, $urandom_range(0, 2), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_vctr_store
